// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// ALUOp classes consumed by the ALU controller, opcodes, and mux select codes.
// No ports; imported by the controller, its branch decider and the ALU controller.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_R_EXEC,
      S_I_EXEC,
      S_ALU_WB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_LINK,
      S_LUI
   } state_t;

   // ALUOp classes, resolved further by the ALU controller using func3/func7
   localparam logic [1:0] ALUOP_LW_SW = 2'd0;  // ADD
   localparam logic [1:0] ALUOP_B_T   = 2'd1;  // SUB
   localparam logic [1:0] ALUOP_R_T   = 2'd2;
   localparam logic [1:0] ALUOP_I_T   = 2'd3;

   // Opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Branch func3 codes
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT    = 2'd0;
   localparam logic [1:0] RES_MEMDATA   = 2'd1;
   localparam logic [1:0] RES_ALURESULT = 2'd2;
   localparam logic [1:0] RES_IMM       = 2'd3;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;

   // ALUSrcB
   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   // ImmSrc
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

endpackage

// File: rtl/multicycle_controller_branch_decider.sv
// Branch condition evaluation after the SUB in the BRANCH cycle.
// Ports: i_func3 (branch kind), i_zero / i_neg (ALU flags) -> o_taken.
// Purely combinational; unsupported func3 codes never take the branch.
module branch_decider
   import multicycle_controller_pkg::*;
(
   input  logic [2:0] i_func3,
   input  logic       i_zero,
   input  logic       i_neg,
   output logic       o_taken
);

   always_comb begin
      o_taken = 1'b0;
      case (i_func3)
         F3_BEQ:  o_taken = i_zero;
         F3_BNE:  o_taken = ~i_zero;
         F3_BLT:  o_taken = i_neg;
         F3_BGE:  o_taken = ~i_neg;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback over 3-5 cycles per instruction.
// Ports: clk/rst (async active-high), op/func3/zero/neg in; datapath selects,
// write strobes, ALUOp, instrDone and illegal pulses out.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] func3,
   input  logic       zero,
   input  logic       neg,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [1:0] ALUOp,
   output logic       instrDone,
   output logic       illegal
);

   state_t r_state;
   state_t w_next_state;
   logic   w_taken;

   branch_decider u_branch_decider (
      .i_func3 (func3),
      .i_zero  (zero),
      .i_neg   (neg),
      .o_taken (w_taken)
   );

   // Reset lands in IDLE, whose outputs are all zero, so an interrupted
   // MEM_WRITE or writeback loses its strobe as soon as rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_IDLE:   w_next_state = S_FETCH;
         S_FETCH:  w_next_state = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_R:                w_next_state = S_R_EXEC;
               OP_I:                w_next_state = S_I_EXEC;
               OP_LOAD, OP_STORE:   w_next_state = S_MEM_ADDR;
               OP_BRANCH:           w_next_state = S_BRANCH;
               OP_JAL:              w_next_state = S_JAL;
               OP_JALR:             w_next_state = S_JALR;
               OP_LUI:              w_next_state = S_LUI;
               default:             w_next_state = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  w_next_state = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  w_next_state = S_MEM_WB;
         S_R_EXEC:    w_next_state = S_ALU_WB;
         S_I_EXEC:    w_next_state = S_ALU_WB;
         S_JAL:       w_next_state = S_ALU_WB;
         S_JALR:      w_next_state = S_LINK;
         S_LINK:      w_next_state = S_ALU_WB;
         default:     w_next_state = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ImmSrc    = IMM_I;
      ALUOp     = ALUOP_LW_SW;
      instrDone = 1'b0;
      illegal   = 1'b0;
      case (r_state)
         S_FETCH: begin
            // PC <= PC + 4 while the IR loads
            IRWrite   = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            PCWrite   = 1'b1;
         end
         S_DECODE: begin
            // ALUOut <= OldPC + imm: the branch/jump target, computed speculatively
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
            case (op)
               OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
               OP_JAL, OP_JALR, OP_LUI: illegal = 1'b0;
               default:                 illegal = 1'b1;
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_LOAD) ? IMM_I : IMM_S;
         end
         S_MEM_READ: AdrSrc = 1'b1;
         S_MEM_WB: begin
            ResultSrc = RES_MEMDATA;
            RegWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_MEM_WRITE: begin
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_R_EXEC: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_R_T;
         end
         S_I_EXEC: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_I_T;
         end
         S_ALU_WB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_BRANCH: begin
            // ALU compares rs1-rs2 while ALUOut still holds the target from DECODE
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_RS2;
            ALUOp     = ALUOP_B_T;
            ResultSrc = RES_ALUOUT;
            PCWrite   = w_taken;
            instrDone = 1'b1;
         end
         S_JAL: begin
            // PC <= target held in ALUOut; ALU forms the link value OldPC + 4
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALUOUT;
            PCWrite   = 1'b1;
         end
         S_JALR: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
            PCWrite   = 1'b1;
         end
         S_LINK: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
         end
         S_LUI: begin
            ImmSrc    = IMM_U;
            ResultSrc = RES_IMM;
            RegWrite  = 1'b1;
            instrDone = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
